fiber_tx: RTL

Fiber command transmitter for the power-unit link, driving the serial line that the unit-side fiber receiver decodes. It sends frames back to back with no gaps, so the receiver's loss-of-signal check always sees activity. Each frame carries a 4-bit command (2 IGBT-control bits and 2 unit-control bits) plus an even-parity bit. Reset and bypass commands are one-shot requests, each repeated for a fixed number of frames so the receiver's N-consecutive-frame debounce accepts them.

---
 rtl/fiber_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fiber_tx.sv
// fiber_tx: serial command transmitter for the power-unit fiber link.
// Sends back-to-back frames (idle high, start low, 4 command bits + even parity,
// MSB first) and stretches one-shot reset/bypass requests into multi-frame bursts.
module fiber_tx #(
    parameter int unsigned BIT_CLKS       = 10,
    parameter int unsigned IDLE_BITS      = 7,
    parameter int unsigned DATA_BITS_SIZE = 5,
    parameter int unsigned RST_FRAMES     = 4,
    parameter int unsigned BYP_FRAMES     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tx_en,
    input  logic                      run_cmd,
    input  logic [1:0]                igbt_cmd,
    input  logic                      reset_req,
    input  logic                      byp_req,
    output logic                      COMM_T,
    output logic                      frame_start,
    output logic                      burst_active,
    output logic [DATA_BITS_SIZE-1:0] tx_word
);

    localparam int unsigned IDLE_CLKS  = IDLE_BITS * BIT_CLKS;
    localparam int unsigned CNT_W      = $clog2(IDLE_CLKS + 1);
    localparam int unsigned BIT_W      = (DATA_BITS_SIZE > 1) ? $clog2(DATA_BITS_SIZE) : 1;
    localparam int unsigned MAX_FRAMES = (RST_FRAMES > BYP_FRAMES) ? RST_FRAMES : BYP_FRAMES;
    localparam int unsigned FRM_W      = $clog2(MAX_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [BIT_W-1:0]          bit_idx, bit_idx_n;
    logic [DATA_BITS_SIZE-1:0] shreg, shreg_n;
    logic                      comm_t_n, frame_start_n, burst_n;
    logic [DATA_BITS_SIZE-1:0] word_n;
    logic                      rst_pend, rst_pend_n, byp_pend, byp_pend_n;
    logic [FRM_W-1:0]          rst_cnt, rst_cnt_n, byp_cnt, byp_cnt_n;
    logic [1:0]                cmd_lo;
    logic [3:0]                cmd;

    // Next-state, line level, request latching and frame-boundary burst selection
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        comm_t_n      = COMM_T;
        frame_start_n = 1'b0;
        burst_n       = burst_active;
        word_n        = tx_word;
        rst_pend_n    = rst_pend | reset_req;
        byp_pend_n    = byp_pend | byp_req;
        rst_cnt_n     = rst_cnt;
        byp_cnt_n     = byp_cnt;
        cmd_lo        = 2'b00;
        cmd           = 4'b0000;

        case (state)
            ST_IDLE: begin
                if (cnt == CNT_W'(IDLE_CLKS) && tx_en) begin
                    // Frame boundary: a reset request pre-empts everything,
                    // a bypass only starts once no reset burst is running.
                    if (rst_pend_n) begin
                        rst_cnt_n  = FRM_W'(RST_FRAMES - 1);
                        byp_cnt_n  = '0;
                        rst_pend_n = 1'b0;
                        cmd_lo     = 2'b11;
                    end else if (rst_cnt != '0) begin
                        rst_cnt_n  = rst_cnt - FRM_W'(1);
                        cmd_lo     = 2'b11;
                    end else if (byp_pend_n) begin
                        byp_cnt_n  = FRM_W'(BYP_FRAMES - 1);
                        byp_pend_n = 1'b0;
                        cmd_lo     = 2'b10;
                    end else if (byp_cnt != '0) begin
                        byp_cnt_n  = byp_cnt - FRM_W'(1);
                        cmd_lo     = 2'b10;
                    end else begin
                        cmd_lo     = {1'b0, run_cmd};
                    end
                    cmd           = {igbt_cmd, cmd_lo};
                    word_n        = DATA_BITS_SIZE'({cmd, ^cmd});
                    shreg_n       = word_n;
                    burst_n       = cmd_lo[1];
                    state_n       = ST_START;
                    cnt_n         = '0;
                    comm_t_n      = 1'b0;
                    frame_start_n = 1'b1;
                end else begin
                    comm_t_n = 1'b1;
                    if (cnt != CNT_W'(IDLE_CLKS)) begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            ST_START: begin
                comm_t_n = 1'b0;
                if (cnt == CNT_W'(BIT_CLKS - 1)) begin
                    state_n   = ST_DATA;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    comm_t_n  = shreg[DATA_BITS_SIZE-1];
                    shreg_n   = {shreg[DATA_BITS_SIZE-2:0], 1'b0};
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == CNT_W'(BIT_CLKS - 1)) begin
                    cnt_n = '0;
                    if (bit_idx == BIT_W'(DATA_BITS_SIZE - 1)) begin
                        // The transition clock already drives high, so it counts as idle clock 1.
                        state_n  = ST_IDLE;
                        cnt_n    = CNT_W'(1);
                        comm_t_n = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + BIT_W'(1);
                        comm_t_n  = shreg[DATA_BITS_SIZE-1];
                        shreg_n   = {shreg[DATA_BITS_SIZE-2:0], 1'b0};
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n  = ST_IDLE;
                cnt_n    = '0;
                comm_t_n = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset forces the line high immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            COMM_T       <= 1'b1;
            frame_start  <= 1'b0;
            burst_active <= 1'b0;
            tx_word      <= '0;
            rst_pend     <= 1'b0;
            byp_pend     <= 1'b0;
            rst_cnt      <= '0;
            byp_cnt      <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            shreg        <= shreg_n;
            COMM_T       <= comm_t_n;
            frame_start  <= frame_start_n;
            burst_active <= burst_n;
            tx_word      <= word_n;
            rst_pend     <= rst_pend_n;
            byp_pend     <= byp_pend_n;
            rst_cnt      <= rst_cnt_n;
            byp_cnt      <= byp_cnt_n;
        end
    end

endmodule
